lsu_stage: RTL and testbench

- Parametrised load/store pipeline stage between execute and writeback. Successor to the single-cycle word-only memory stage.
- Adds byte/halfword/word accesses with sign/zero extension and byte-enable stores.
- Adds a multi-cycle request/ready handshake to data memory, a response hold buffer for downstream stalls, and an access-timeout fault.

---
 rtl/lsu_stage_pkg.sv | 35 +++
 rtl/lsu_stage_align.sv | 52 +++++
 rtl/lsu_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_lsu_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: opcodes, access sizes,
// exception codes, FSM state encoding and a size-to-offset-mask helper.
package lsu_stage_pkg;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } lsu_state_e;

  // Address bits that must be zero for an access of the given size.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE:   size_mask = 3'b000;
      SZ_HALF:   size_mask = 3'b001;
      SZ_WORD:   size_mask = 3'b011;
      SZ_DOUBLE: size_mask = 3'b111;
      default:   size_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_stage_align.sv
// Byte-lane steering: store data shift, store byte enables, load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [1:0]       st_size,
  input  logic [OFF_W-1:0] st_offset,
  input  logic [XLEN-1:0]  st_data,
  output logic [XLEN-1:0]  wr_data,
  output logic [NB-1:0]    byte_en,
  input  logic [1:0]       ld_size,
  input  logic [OFF_W-1:0] ld_offset,
  input  logic             ld_unsigned,
  input  logic [XLEN-1:0]  rd_data,
  output logic [XLEN-1:0]  ld_data
);

  logic [NB-1:0]   be_base_s;
  logic [XLEN-1:0] ld_shift_s;

  // Store path: move data and lane mask up to the addressed byte.
  always_comb begin
    wr_data = st_data << {st_offset, 3'b000};
    case (st_size)
      SZ_BYTE:   be_base_s = NB'(8'h01);
      SZ_HALF:   be_base_s = NB'(8'h03);
      SZ_WORD:   be_base_s = NB'(8'h0F);
      SZ_DOUBLE: be_base_s = NB'(8'hFF);
      default:   be_base_s = NB'(8'h00);
    endcase
    byte_en = be_base_s << st_offset;
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift_s = rd_data >> {ld_offset, 3'b000};
    case (ld_size)
      SZ_BYTE: ld_data = ld_unsigned ? XLEN'(ld_shift_s[7:0])
                                     : XLEN'($signed(ld_shift_s[7:0]));
      SZ_HALF: ld_data = ld_unsigned ? XLEN'(ld_shift_s[15:0])
                                     : XLEN'($signed(ld_shift_s[15:0]));
      SZ_WORD: ld_data = ld_unsigned ? XLEN'(ld_shift_s[31:0])
                                     : XLEN'($signed(ld_shift_s[31:0]));
      default: ld_data = ld_shift_s;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage with request/ready memory handshake, a hold
// buffer for downstream stalls and an access timeout fault.
// Build option: define LSU_MISALIGN_EX_EN to trap misaligned accesses
// (codes 4/6) instead of silently aligning them down.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int EX_W       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  stall_in,
  input  logic                  pipeline_in_valid,
  input  logic [4:0]            opcode_in,
  input  logic [2:0]            funct_in,
  input  logic                  nop_instr_in,
  input  logic [EX_W-1:0]       exception_in,
  input  logic                  exception_in_valid,
  input  logic [XLEN-1:0]       result_in,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  output logic                  pipeline_out_valid,
  output logic                  nop_instr_out,
  output logic [XLEN-1:0]       result_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [EX_W-1:0]       exception_out,
  output logic                  exception_out_valid,
  output logic                  stall_out,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [XLEN-1:0]       mem_wr_data,
  output logic [XLEN/8-1:0]     mem_byte_en,
  output logic                  mem_wr_enable,
  output logic                  mem_rd_enable,
  input  logic [XLEN-1:0]       mem_rd_data,
  input  logic                  mem_ready
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e state_r, next_state_s;

  logic                  is_load_s, is_store_s, mem_op_s, illegal_s;
  logic                  local_ex_s, go_mem_s, done_s, timeout_s;
  logic [1:0]            size_s;
  logic [OFF_W-1:0]      mask_s, eff_off_s;
  logic [XLEN-1:0]       st_data_s, ld_data_s;
  logic [NB-1:0]         be_s;
  logic [EX_W-1:0]       mis_code_s;
  logic [XLEN-1:0]       resp_result_s;
  logic [EX_W-1:0]       resp_ex_s;
  logic                  resp_ex_valid_s;

  logic                  req_load_r, uns_r;
  logic [1:0]            size_r;
  logic [OFF_W-1:0]      off_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [XLEN-1:0]       hold_result_r;
  logic [EX_W-1:0]       hold_ex_r;
  logic                  hold_ex_valid_r;

  lsu_align #(.XLEN(XLEN), .NB(NB), .OFF_W(OFF_W)) u_align (
    .st_size    (size_s),
    .st_offset  (eff_off_s),
    .st_data    (result_in),
    .wr_data    (st_data_s),
    .byte_en    (be_s),
    .ld_size    (size_r),
    .ld_offset  (off_r),
    .ld_unsigned(uns_r),
    .rd_data    (mem_rd_data),
    .ld_data    (ld_data_s)
  );

  // Decode the incoming op: access type, legality, alignment, lane offset.
  always_comb begin
    is_load_s  = (opcode_in == OP_LOAD);
    is_store_s = (opcode_in == OP_STORE);
    mem_op_s   = pipeline_in_valid && !nop_instr_in && (is_load_s || is_store_s);
    size_s     = funct_in[1:0];
    mask_s     = OFF_W'(size_mask(size_s));
    if (size_s == SZ_DOUBLE) begin
      illegal_s = (XLEN == 32) || funct_in[2];
    end else begin
      illegal_s = is_store_s && funct_in[2];
    end
`ifdef LSU_MISALIGN_EX_EN
    eff_off_s  = addr[OFF_W-1:0];
    local_ex_s = illegal_s || ((addr[OFF_W-1:0] & mask_s) != {OFF_W{1'b0}});
`else
    eff_off_s  = addr[OFF_W-1:0] & ~mask_s;
    local_ex_s = illegal_s;
`endif
    go_mem_s   = mem_op_s && !exception_in_valid && !local_ex_s;
    mis_code_s = is_load_s ? EX_W'(EXC_LD_MISALIGN) : EX_W'(EXC_ST_MISALIGN);
  end

  // Completion of the outstanding access; mem_ready beats the timeout.
  always_comb begin
    done_s          = (state_r == ST_WAIT) && mem_ready;
    timeout_s       = (state_r == ST_WAIT) && !mem_ready && (cnt_r == CNT_W'(TIMEOUT - 1));
    resp_result_s   = (req_load_r && done_s) ? ld_data_s : {XLEN{1'b0}};
    resp_ex_valid_s = timeout_s;
    if (timeout_s) begin
      resp_ex_s = req_load_r ? EX_W'(EXC_LD_FAULT) : EX_W'(EXC_ST_FAULT);
    end else begin
      resp_ex_s = {EX_W{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: next_state_s = (!stall_in && go_mem_s) ? ST_WAIT : ST_IDLE;
        ST_WAIT: begin
          if (done_s || timeout_s) next_state_s = stall_in ? ST_HOLD : ST_IDLE;
          else                     next_state_s = ST_WAIT;
        end
        ST_HOLD: next_state_s = stall_in ? ST_HOLD : ST_IDLE;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Upstream hold: busy with memory, or about to start an access.
  always_comb begin
    if (state_r != ST_IDLE) stall_out = 1'b1;
    else                    stall_out = go_mem_s;
  end

  // Datapath and registered outputs. A flush only drops the bus enables;
  // a store already acknowledged by mem_ready is complete in memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipeline_out_valid  <= 1'b0;
      nop_instr_out       <= 1'b0;
      result_out          <= {XLEN{1'b0}};
      rd_addr_out         <= {REG_ADDR_W{1'b0}};
      exception_out       <= {EX_W{1'b0}};
      exception_out_valid <= 1'b0;
      mem_addr            <= {ADDR_W{1'b0}};
      mem_wr_data         <= {XLEN{1'b0}};
      mem_byte_en         <= {NB{1'b0}};
      mem_wr_enable       <= 1'b0;
      mem_rd_enable       <= 1'b0;
      req_load_r          <= 1'b0;
      uns_r               <= 1'b0;
      size_r              <= 2'b00;
      off_r               <= {OFF_W{1'b0}};
      rd_r                <= {REG_ADDR_W{1'b0}};
      cnt_r               <= {CNT_W{1'b0}};
      hold_result_r       <= {XLEN{1'b0}};
      hold_ex_r           <= {EX_W{1'b0}};
      hold_ex_valid_r     <= 1'b0;
    end else if (flush) begin
      pipeline_out_valid  <= 1'b0;
      exception_out_valid <= 1'b0;
      mem_wr_enable       <= 1'b0;
      mem_rd_enable       <= 1'b0;
      cnt_r               <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!stall_in && pipeline_in_valid) begin
            pipeline_out_valid <= !go_mem_s;
            nop_instr_out      <= nop_instr_in;
            result_out         <= result_in;
            rd_addr_out        <= rd_addr_in;
            if (exception_in_valid) begin
              exception_out       <= exception_in;
              exception_out_valid <= 1'b1;
            end else if (mem_op_s && local_ex_s) begin
              exception_out       <= mis_code_s;
              exception_out_valid <= 1'b1;
            end else begin
              exception_out       <= {EX_W{1'b0}};
              exception_out_valid <= 1'b0;
            end
            if (go_mem_s) begin
              mem_addr      <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wr_data   <= is_store_s ? st_data_s : {XLEN{1'b0}};
              mem_byte_en   <= is_store_s ? be_s : {NB{1'b0}};
              mem_wr_enable <= is_store_s;
              mem_rd_enable <= is_load_s;
              req_load_r    <= is_load_s;
              uns_r         <= funct_in[2];
              size_r        <= size_s;
              off_r         <= eff_off_s;
              rd_r          <= rd_addr_in;
              cnt_r         <= {CNT_W{1'b0}};
            end
          end else if (!stall_in) begin
            pipeline_out_valid  <= 1'b0;
            exception_out_valid <= 1'b0;
            nop_instr_out       <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (done_s || timeout_s) begin
            mem_wr_enable <= 1'b0;
            mem_rd_enable <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            if (stall_in) begin
              hold_result_r   <= resp_result_s;
              hold_ex_r       <= resp_ex_s;
              hold_ex_valid_r <= resp_ex_valid_s;
            end else begin
              pipeline_out_valid  <= 1'b1;
              nop_instr_out       <= 1'b0;
              result_out          <= resp_result_s;
              rd_addr_out         <= rd_r;
              exception_out       <= resp_ex_s;
              exception_out_valid <= resp_ex_valid_s;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!stall_in) begin
            pipeline_out_valid  <= 1'b1;
            nop_instr_out       <= 1'b0;
            result_out          <= hold_result_r;
            rd_addr_out         <= rd_r;
            exception_out       <= hold_ex_r;
            exception_out_valid <= hold_ex_valid_r;
          end
        end
        default: begin
          mem_wr_enable <= 1'b0;
          mem_rd_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage (XLEN=32, TIMEOUT=16).
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        reset, flush, stall_in, pipeline_in_valid, nop_instr_in;
  logic [4:0]  opcode_in, rd_addr_in, rd_addr_out;
  logic [2:0]  funct_in;
  logic [3:0]  exception_in, exception_out, mem_byte_en;
  logic        exception_in_valid, exception_out_valid;
  logic [31:0] result_in, addr, result_out, mem_addr, mem_wr_data, mem_rd_data;
  logic        pipeline_out_valid, nop_instr_out, stall_out;
  logic        mem_wr_enable, mem_rd_enable, mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  lsu_stage #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5), .EX_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall_in(stall_in),
    .pipeline_in_valid(pipeline_in_valid), .opcode_in(opcode_in),
    .funct_in(funct_in), .nop_instr_in(nop_instr_in),
    .exception_in(exception_in), .exception_in_valid(exception_in_valid),
    .result_in(result_in), .addr(addr), .rd_addr_in(rd_addr_in),
    .pipeline_out_valid(pipeline_out_valid), .nop_instr_out(nop_instr_out),
    .result_out(result_out), .rd_addr_out(rd_addr_out),
    .exception_out(exception_out), .exception_out_valid(exception_out_valid),
    .stall_out(stall_out), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_byte_en(mem_byte_en), .mem_wr_enable(mem_wr_enable),
    .mem_rd_enable(mem_rd_enable), .mem_rd_data(mem_rd_data),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    pipeline_in_valid = v;
    opcode_in         = op;
    funct_in          = f;
    addr              = a;
    result_in         = d;
    rd_addr_in        = rd;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0; nop_instr_in = 1'b0;
    exception_in = 4'd0; exception_in_valid = 1'b0;
    mem_rd_data = 32'h0; mem_ready = 1'b0;
    drive(1'b0, 5'b00000, 3'b000, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_valid", pipeline_out_valid, 1'b0);
    check("rst_result", result_out, 32'h0);
    check("rst_rd_en", mem_rd_enable, 1'b0);
    check("rst_wr_en", mem_wr_enable, 1'b0);
    check("rst_stall", stall_out, 1'b0);
    check("rst_ex_valid", exception_out_valid, 1'b0);

    // ALU pass-through
    drive(1'b1, 5'b01100, 3'b000, 32'h0, 32'hDEADBEEF, 5'd5);
    check("alu_stall", stall_out, 1'b0);
    tick();
    check("alu_valid", pipeline_out_valid, 1'b1);
    check("alu_result", result_out, 32'hDEADBEEF);
    check("alu_rd", rd_addr_out, 5'd5);

    // LB from 0x103, ready in the second WAIT cycle
    drive(1'b1, 5'b00000, 3'b000, 32'h103, 32'h0, 5'd7);
    check("lb_stall0", stall_out, 1'b1);
    tick();
    drive(1'b0, 5'b01100, 3'b000, 32'h0, 32'h0, 5'd0);
    check("lb_stall1", stall_out, 1'b1);
    check("lb_rd_en", mem_rd_enable, 1'b1);
    check("lb_addr", mem_addr, 32'h100);
    check("lb_wait_valid", pipeline_out_valid, 1'b0);
    tick();
    check("lb_stall2", stall_out, 1'b1);
    mem_ready = 1'b1; mem_rd_data = 32'h80AABBCC;
    tick();
    mem_ready = 1'b0;
    #1;
    check("lb_stall_done", stall_out, 1'b0);
    check("lb_valid", pipeline_out_valid, 1'b1);
    check("lb_result", result_out, 32'hFFFFFF80);
    check("lb_rd", rd_addr_out, 5'd7);
    check("lb_rd_en_off", mem_rd_enable, 1'b0);
    tick();
    check("lb_once", pipeline_out_valid, 1'b0);

    // SH 0x1234ABCD to 0x202
    drive(1'b1, 5'b01000, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
    tick();
    drive(1'b0, 5'b01100, 3'b000, 32'h0, 32'h0, 5'd0);
    check("sh_addr", mem_addr, 32'h200);
    check("sh_be", mem_byte_en, 4'b1100);
    check("sh_data", mem_wr_data, 32'hABCD0000);
    check("sh_wr_en", mem_wr_enable, 1'b1);
    tick();
    check("sh_wr_en_held", mem_wr_enable, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    check("sh_wr_en_off", mem_wr_enable, 1'b0);
    check("sh_valid", pipeline_out_valid, 1'b1);
    check("sh_ex_valid", exception_out_valid, 1'b0);
    tick();

    // LW timeout: fault after exactly 16 WAIT cycles
    drive(1'b1, 5'b00000, 3'b010, 32'h300, 32'h0, 5'd4);
    tick();
    drive(1'b0, 5'b01100, 3'b000, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 15; i++) tick();
    check("to_not_early_rd_en", mem_rd_enable, 1'b1);
    check("to_not_early_ex", exception_out_valid, 1'b0);
    tick();
    check("to_ex", exception_out, 4'd5);
    check("to_ex_valid", exception_out_valid, 1'b1);
    check("to_rd_en", mem_rd_enable, 1'b0);
    check("to_stall", stall_out, 1'b0);
    tick();

    // LHU at 0x101
    drive(1'b1, 5'b00000, 3'b101, 32'h101, 32'h0, 5'd6);
    tick();
    drive(1'b0, 5'b01100, 3'b000, 32'h0, 32'h0, 5'd0);
`ifdef LSU_MISALIGN_EX_EN
    check("lhu_ex", exception_out, 4'd4);
    check("lhu_ex_valid", exception_out_valid, 1'b1);
    check("lhu_rd_en", mem_rd_enable, 1'b0);
`else
    check("lhu_addr", mem_addr, 32'h100);
    check("lhu_rd_en", mem_rd_enable, 1'b1);
    mem_ready = 1'b1; mem_rd_data = 32'h80AABBCC;
    tick();
    mem_ready = 1'b0;
    #1;
    check("lhu_result", result_out, 32'h0000BBCC);
    check("lhu_valid", pipeline_out_valid, 1'b1);
`endif
    tick();

    // LH completes under downstream stall -> HOLD
    drive(1'b1, 5'b00000, 3'b001, 32'h102, 32'h0, 5'd9);
    tick();
    drive(1'b0, 5'b01100, 3'b000, 32'h0, 32'h0, 5'd0);
    mem_ready = 1'b1; mem_rd_data = 32'hF00D1234; stall_in = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    check("hold_valid0", pipeline_out_valid, 1'b0);
    check("hold_stall", stall_out, 1'b1);
    tick(); tick();
    check("hold_valid1", pipeline_out_valid, 1'b0);
    stall_in = 1'b0;
    tick();
    check("hold_emit_valid", pipeline_out_valid, 1'b1);
    check("hold_result", result_out, 32'hFFFFF00D);
    check("hold_rd", rd_addr_out, 5'd9);
    tick();
    check("hold_once", pipeline_out_valid, 1'b0);

    // Flush during WAIT, then an ALU op
    drive(1'b1, 5'b00000, 3'b010, 32'h400, 32'h0, 5'd2);
    tick();
    drive(1'b0, 5'b01100, 3'b000, 32'h0, 32'h0, 5'd0);
    check("fl_rd_en_pre", mem_rd_enable, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("fl_rd_en", mem_rd_enable, 1'b0);
    check("fl_valid", pipeline_out_valid, 1'b0);
    check("fl_stall", stall_out, 1'b0);
    drive(1'b1, 5'b01100, 3'b000, 32'h0, 32'h5A5A0001, 5'd3);
    tick();
    check("fl_alu_valid", pipeline_out_valid, 1'b1);
    check("fl_alu_result", result_out, 32'h5A5A0001);

    // Upstream exception pass-through, then IDLE stall holds outputs
    exception_in = 4'd2; exception_in_valid = 1'b1;
    drive(1'b1, 5'b00000, 3'b010, 32'h500, 32'h11112222, 5'd1);
    check("exin_stall", stall_out, 1'b0);
    tick();
    exception_in_valid = 1'b0;
    check("exin_code", exception_out, 4'd2);
    check("exin_valid", exception_out_valid, 1'b1);
    check("exin_rd_en", mem_rd_enable, 1'b0);
    stall_in = 1'b1;
    drive(1'b1, 5'b01100, 3'b000, 32'h0, 32'h33334444, 5'd8);
    tick();
    check("stall_hold_result", result_out, 32'h11112222);
    check("stall_hold_valid", pipeline_out_valid, 1'b1);
    stall_in = 1'b0;

    // Illegal double access on XLEN=32
    drive(1'b1, 5'b00000, 3'b011, 32'h500, 32'h0, 5'd1);
    tick();
    check("ld_ill_ex", exception_out, 4'd4);
    check("ld_ill_rd_en", mem_rd_enable, 1'b0);
    drive(1'b1, 5'b01000, 3'b011, 32'h500, 32'h0, 5'd0);
    tick();
    check("sd_ill_ex", exception_out, 4'd6);
    check("sd_ill_wr_en", mem_wr_enable, 1'b0);
    drive(1'b0, 5'b01100, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
